// File: rtl/dec_3to8_hold_if.sv
// Purpose : valid/ready handshake carrying a 3-bit code into dec_3to8_hold.
// Latency : n/a (wiring only).
// Backpressure: in_ready from the slave gates acceptance; a code is taken when in_valid & in_ready.
//
// Ports / signals:
//   in_valid  master -> slave  code on in_code is valid
//   in_code   master -> slave  3-bit index, bit 2 is the MSB
//   in_ready  slave -> master  slave accepts a code this cycle
interface dec_3to8_hold_if;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_code,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_code,
        output in_ready
    );
endinterface

// File: rtl/dec_3to8_hold.sv
// Purpose : sequential 3-to-8 one-hot decoder, holds each line HOLD_CYCLES then idles GAP_CYCLES.
// Latency : d valid the cycle after accept, held HOLD_CYCLES; ready again HOLD_CYCLES+GAP_CYCLES after accept.
// Backpressure: in_ready is high only in IDLE; codes offered while busy wait until the next IDLE cycle.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   in_if    slave side of the valid/ready code handshake
//   d        one-hot output, d[code] high while holding, otherwise 8'h00
//   done     high during the final hold cycle of each code
//   busy     high while holding or gapping
//   evt_cnt  accepted-code count, saturating at 16'hFFFF
module dec_3to8_hold #(
    parameter int HOLD_CYCLES = 4,   // 1..255
    parameter int GAP_CYCLES  = 1    // 0..255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dec_3to8_hold_if.slave        in_if,
    output logic [7:0]            d,
    output logic                  done,
    output logic                  busy,
    output logic [15:0]           evt_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Counter reload values; cnt counts down to zero, so a load of N-1
    // yields N cycles in the state.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

    state_t      state_q, state_nxt;
    logic [7:0]  cnt_q,   cnt_nxt;
    logic [7:0]  d_q,     d_nxt;
    logic [15:0] evt_cnt_q, evt_cnt_nxt;
    logic        accept;

    // Ready is a pure decode of the state register so no combinational
    // path exists from in_valid back to in_ready.
    assign in_if.in_ready = (state_q == ST_IDLE);
    assign accept         = in_if.in_valid && (state_q == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            d_q       <= 8'h00;
            evt_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            d_q       <= d_nxt;
            evt_cnt_q <= evt_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        d_nxt       = d_q;
        evt_cnt_nxt = evt_cnt_q;

        case (state_q)
            ST_IDLE: begin
                d_nxt = 8'h00;
                if (accept) begin
                    d_nxt     = 8'h01 << in_if.in_code;
                    cnt_nxt   = HOLD_LOAD;
                    state_nxt = ST_HOLD;
                    if (evt_cnt_q != 16'hFFFF) begin
                        evt_cnt_nxt = evt_cnt_q + 16'd1;
                    end
                end
            end

            ST_HOLD: begin
                // in_code / in_valid are deliberately ignored here.
                if (cnt_q != 8'd0) begin
                    cnt_nxt = cnt_q - 8'd1;
                end else begin
                    d_nxt = 8'h00;
                    if (GAP_CYCLES == 0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt   = GAP_LOAD;
                        state_nxt = ST_GAP;
                    end
                end
            end

            ST_GAP: begin
                d_nxt = 8'h00;
                if (cnt_q != 8'd0) begin
                    cnt_nxt = cnt_q - 8'd1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 8'd0;
                d_nxt     = 8'h00;
            end
        endcase
    end

    assign d       = d_q;
    assign done    = (state_q == ST_HOLD) && (cnt_q == 8'd0);
    assign busy    = (state_q != ST_IDLE);
    assign evt_cnt = evt_cnt_q;

endmodule

// File: tb/tb_dec_3to8_hold.sv
// Bench for dec_3to8_hold: two instances (HOLD=4/GAP=1 and HOLD=1/GAP=0)
// checked every cycle against a time-based model, plus directed literal checks.
module tb_dec_3to8_hold;

    localparam int HA = 4, GA = 1;
    localparam int HB = 1, GB = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dec_3to8_hold_if if_a ();
    dec_3to8_hold_if if_b ();

    logic [7:0]  d_a, d_b;
    logic        done_a, done_b, busy_a, busy_b;
    logic [15:0] evt_a, evt_b;

    dec_3to8_hold #(.HOLD_CYCLES(HA), .GAP_CYCLES(GA)) u_a (
        .clk(clk), .rst_n(rst_n), .in_if(if_a),
        .d(d_a), .done(done_a), .busy(busy_a), .evt_cnt(evt_a)
    );

    dec_3to8_hold #(.HOLD_CYCLES(HB), .GAP_CYCLES(GB)) u_b (
        .clk(clk), .rst_n(rst_n), .in_if(if_b),
        .d(d_b), .done(done_b), .busy(busy_b), .evt_cnt(evt_b)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each instance is described only by the edge index of its last accept
    // and the accepted code: outputs follow from the distance to that edge.
    int         edge_n = 0;
    int         last_k [2];
    logic [2:0] code_m [2];
    int         evt_m  [2];
    int         hold_m [2];
    int         gap_m  [2];

    function automatic logic dut_vld(input int i);
        return (i == 0) ? if_a.in_valid : if_b.in_valid;
    endfunction
    function automatic logic [2:0] dut_code(input int i);
        return (i == 0) ? if_a.in_code : if_b.in_code;
    endfunction
    function automatic logic dut_rdy(input int i);
        return (i == 0) ? if_a.in_ready : if_b.in_ready;
    endfunction

    function automatic logic model_idle(input int i, input int e);
        return (e - last_k[i]) >= (hold_m[i] + gap_m[i]);
    endfunction

    initial begin
        hold_m[0] = HA; gap_m[0] = GA;
        hold_m[1] = HB; gap_m[1] = GB;
        for (int i = 0; i < 2; i++) begin
            last_k[i] = -100000; code_m[i] = 3'd0; evt_m[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    last_k[i] = -100000; evt_m[i] = 0;
                end
            end else begin
                edge_n++;
                for (int i = 0; i < 2; i++) begin
                    if (dut_vld(i) && model_idle(i, edge_n - 1)) begin
                        last_k[i] = edge_n;
                        code_m[i] = dut_code(i);
                        if (evt_m[i] < 65535) evt_m[i]++;
                    end
                end
            end
        end
    end

    // Compare process: every falling edge, both instances.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                int         delta;
                logic [7:0] one8, ed, ad;
                logic       adone, abusy;
                logic [15:0] aevt;
                delta = edge_n - last_k[i];
                one8  = 8'h01;
                ed    = (delta < hold_m[i]) ? (one8 << code_m[i]) : 8'h00;
                ad    = (i == 0) ? d_a : d_b;
                adone = (i == 0) ? done_a : done_b;
                abusy = (i == 0) ? busy_a : busy_b;
                aevt  = (i == 0) ? evt_a : evt_b;
                chk($sformatf("d[%0d]", i), 32'(ad), 32'(ed));
                chk($sformatf("done[%0d]", i), 32'(adone), 32'(delta == hold_m[i] - 1));
                chk($sformatf("busy[%0d]", i), 32'(abusy), 32'(delta < hold_m[i] + gap_m[i]));
                chk($sformatf("in_ready[%0d]", i), 32'(dut_rdy(i)), 32'(!(delta < hold_m[i] + gap_m[i])));
                chk($sformatf("evt_cnt[%0d]", i), 32'(aevt), 32'(evt_m[i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_rdy(input int i);
        int n;
        n = 0;
        while (!dut_rdy(i) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!dut_rdy(i)) chk("ready_timeout", 32'(dut_rdy(i)), 32'd1);
    endtask

    initial begin
        logic [7:0]  one8, exp8;
        logic [15:0] e0;
        int          n;
        one8 = 8'h01;
        if_a.in_valid = 1'b0; if_a.in_code = 3'd0;
        if_b.in_valid = 1'b0; if_b.in_code = 3'd0;

        // Reset asserted mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_d", 32'(d_a), 32'h00);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_evt", 32'(evt_a), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_ready", 32'(if_a.in_ready), 32'd1);

        // Sweep codes 0..7 on the HOLD=4/GAP=1 instance.
        for (int c = 0; c < 8; c++) begin
            wait_rdy(0);
            if_a.in_valid = 1'b1; if_a.in_code = 3'(c);
            @(negedge clk);
            if_a.in_valid = 1'b0;
            exp8 = one8 << c;
            chk("sweep_d", 32'(d_a), 32'(exp8));
            n = 0;
            while (!if_a.in_ready && n < 20) begin
                if (n == 3) chk("sweep_done_4th", 32'(done_a), 32'd1);
                n++;
                @(negedge clk);
            end
            chk("sweep_ready_low", 32'(n), 32'd5);
        end
        chk("sweep_evt", 32'(evt_a), 32'd8);

        // Code change during hold is ignored; the new code is taken one
        // edge after ready returns.
        wait_rdy(0);
        if_a.in_valid = 1'b1; if_a.in_code = 3'd3;
        @(negedge clk);
        if_a.in_code = 3'd6;
        chk("midhold_d", 32'(d_a), 32'h08);
        n = 0;
        while (d_a != 8'h40 && n < 20) begin
            if (n < 4) chk("midhold_keep", 32'(d_a), 32'h08);
            @(negedge clk);
            n++;
        end
        chk("midhold_new_at", 32'(n), 32'd6);
        if_a.in_valid = 1'b0;

        // HOLD=1/GAP=0 with in_valid stuck high.
        wait_rdy(1);
        if_b.in_valid = 1'b1; if_b.in_code = 3'd5;
        e0 = evt_b;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            exp8 = (j % 2 == 0) ? 8'h20 : 8'h00;
            chk("b2b_d", 32'(d_b), 32'(exp8));
            chk("b2b_done", 32'(done_b), 32'(j % 2 == 0));
        end
        chk("b2b_evt", 32'(evt_b - e0), 32'd5);
        if_b.in_valid = 1'b0;

        // Random traffic on both instances.
        for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            if_a.in_valid = ($urandom_range(0, 3) != 0);
            if_a.in_code  = 3'($urandom_range(0, 7));
            if_b.in_valid = ($urandom_range(0, 2) != 0);
            if_b.in_code  = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
        if_a.in_valid = 1'b0; if_b.in_valid = 1'b0;

        // Asynchronous reset during hold of code 7.
        wait_rdy(0);
        if_a.in_valid = 1'b1; if_a.in_code = 3'd7;
        @(negedge clk);
        if_a.in_valid = 1'b0;
        chk("arst_pre_d", 32'(d_a), 32'h80);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_d", 32'(d_a), 32'h00);
        chk("arst_busy", 32'(busy_a), 32'd0);
        chk("arst_evt", 32'(evt_a), 32'd0);
        chk("arst_done", 32'(done_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of the event counter.
        wait_rdy(0);
        #2 force u_a.evt_cnt_q = 16'hFFFE;
        evt_m[0] = 65534;
        #1 release u_a.evt_cnt_q;
        @(negedge clk);
        chk("sat_preload", 32'(evt_a), 32'hFFFE);
        for (int j = 0; j < 3; j++) begin
            wait_rdy(0);
            if_a.in_valid = 1'b1; if_a.in_code = 3'(j * 2 + 1);
            @(negedge clk);
            if_a.in_valid = 1'b0;
            exp8 = one8 << (j * 2 + 1);
            chk("sat_d", 32'(d_a), 32'(exp8));
            chk("sat_evt", 32'(evt_a), 32'hFFFF);
        end
        repeat (8) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
